// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller and its forwarding unit.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_IRQ_DRAIN = 2'd2,
    ST_IRQ_ENTER = 2'd3
  } state_e;

  localparam logic [SEL_W-1:0] PC_SEQ = 2'b00;
  localparam logic [SEL_W-1:0] PC_BR  = 2'b01;
  localparam logic [SEL_W-1:0] PC_JMP = 2'b10;
  localparam logic [SEL_W-1:0] PC_IRQ = 2'b11;

  localparam logic [SEL_W-1:0] FWD_RF  = 2'b00;
  localparam logic [SEL_W-1:0] FWD_WB  = 2'b01;
  localparam logic [SEL_W-1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic             pc_en;
    logic [SEL_W-1:0] pc_sel;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             irq_ack;
    logic             mem_timeout;
  } pipe_ctrl_t;

  // Younger producer (EX/MEM) wins over older (MEM/WB); r0 is hard-wired zero.
  function automatic logic [SEL_W-1:0] fwd_pick(
    input logic [REG_W-1:0] src,
    input logic             mem_wr,
    input logic [REG_W-1:0] mem_rd,
    input logic             wb_wr,
    input logic [REG_W-1:0] wb_rd
  );
    logic [SEL_W-1:0] sel;
    sel = FWD_RF;
    if (wb_wr && (wb_rd != '0) && (wb_rd == src)) sel = FWD_WB;
    if (mem_wr && (mem_rd != '0) && (mem_rd == src)) sel = FWD_MEM;
    return sel;
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational operand forwarding selects for the EX stage.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_idex_rs,
  input  logic [REG_W-1:0] i_idex_rt,
  input  logic             i_exmem_regwr,
  input  logic [REG_W-1:0] i_exmem_addrc,
  input  logic             i_memwb_regwr,
  input  logic [REG_W-1:0] i_memwb_addrc,
  output logic [SEL_W-1:0] o_fwd_a,
  output logic [SEL_W-1:0] o_fwd_b
);

  assign o_fwd_a = fwd_pick(i_idex_rs, i_exmem_regwr, i_exmem_addrc,
                            i_memwb_regwr, i_memwb_addrc);
  assign o_fwd_b = fwd_pick(i_idex_rt, i_exmem_regwr, i_exmem_addrc,
                            i_memwb_regwr, i_memwb_addrc);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline: stage enables/flushes, PC control,
// forwarding, load-use stalls, branch/jump squash, data-memory freeze and interrupt entry.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned WAIT_MAX     = 15,
  parameter int unsigned PERF_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        IFID_rs,
  input  logic [4:0]        IFID_rt,
  input  logic              ID_uses_rt,
  input  logic              ID_jump,
  input  logic              IDEX_MemRead,
  input  logic [4:0]        IDEX_AddrC,
  input  logic [4:0]        IDEX_rs,
  input  logic [4:0]        IDEX_rt,
  input  logic              EX_br_taken,
  input  logic              EXMEM_RegWr,
  input  logic [4:0]        EXMEM_AddrC,
  input  logic              MEMWB_RegWr,
  input  logic [4:0]        MEMWB_AddrC,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  input  logic              irq,
  output logic              pc_en,
  output logic [1:0]        pc_sel,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              irq_ack,
  output logic              mem_timeout,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam int unsigned WAIT_W  = $clog2(WAIT_MAX + 1);
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e              r_state;
  state_e              w_state_nxt;
  state_e              r_ret_state;
  state_e              w_ret_nxt;
  state_e              w_act_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic [WAIT_W-1:0]   w_wait_inc;
  logic [DRAIN_W-1:0]  r_drain_cnt;
  logic [DRAIN_W-1:0]  w_drain_nxt;
  logic [PERF_W-1:0]   r_stall_cnt;
  logic                w_load_use;
  logic                w_mem_stall;
  logic                w_timeout;
  logic                w_freeze;
  logic                w_drain_adv;
  pipe_ctrl_t          w_ctrl;

  pipe_fwd_unit u_fwd (
    .i_idex_rs     (IDEX_rs),
    .i_idex_rt     (IDEX_rt),
    .i_exmem_regwr (EXMEM_RegWr),
    .i_exmem_addrc (EXMEM_AddrC),
    .i_memwb_regwr (MEMWB_RegWr),
    .i_memwb_addrc (MEMWB_AddrC),
    .o_fwd_a       (fwd_a),
    .o_fwd_b       (fwd_b)
  );

  assign w_load_use  = IDEX_MemRead && (IDEX_AddrC != 5'd0) &&
                       ((IDEX_AddrC == IFID_rs) || (ID_uses_rt && (IDEX_AddrC == IFID_rt)));
  assign w_mem_stall = dmem_req && !dmem_ready;
  assign w_wait_inc  = r_wait_cnt + WAIT_W'(1);
  // The first frozen cycle (taken in RUN/DRAIN/ENTER) counts as wait cycle one.
  assign w_timeout   = (r_state == ST_MEM_WAIT) && !dmem_ready &&
                       (w_wait_inc == WAIT_W'(WAIT_MAX));

  // Next state and all pipeline controls.
  always_comb begin
    w_ctrl             = '0;
    w_ctrl.pc_en       = 1'b1;
    w_ctrl.pc_sel      = PC_SEQ;
    w_ctrl.ifid_en     = 1'b1;
    w_ctrl.idex_en     = 1'b1;
    w_ctrl.exmem_en    = 1'b1;
    w_ctrl.memwb_en    = 1'b1;
    w_state_nxt        = r_state;
    w_ret_nxt          = r_ret_state;
    w_wait_nxt         = r_wait_cnt;
    w_drain_nxt        = r_drain_cnt;
    w_act_state        = r_state;
    w_freeze           = 1'b0;
    w_drain_adv        = 1'b0;

    if (r_state == ST_MEM_WAIT) begin
      // On release the cycle behaves like the state the freeze interrupted.
      w_act_state = r_ret_state;
      if (dmem_ready || w_timeout) begin
        w_state_nxt        = r_ret_state;
        w_wait_nxt         = '0;
        w_ctrl.mem_timeout = w_timeout;
        w_ctrl.exmem_flush = w_timeout;
      end else begin
        w_freeze   = 1'b1;
        w_wait_nxt = w_wait_inc;
      end
    end else if (w_mem_stall) begin
      w_freeze    = 1'b1;
      w_ret_nxt   = r_state;
      w_state_nxt = ST_MEM_WAIT;
      w_wait_nxt  = WAIT_W'(1);
    end

    if (w_freeze) begin
      w_ctrl.pc_en    = 1'b0;
      w_ctrl.ifid_en  = 1'b0;
      w_ctrl.idex_en  = 1'b0;
      w_ctrl.exmem_en = 1'b0;
      w_ctrl.memwb_en = 1'b0;
    end else begin
      case (w_act_state)
        ST_IRQ_ENTER: begin
          w_ctrl.pc_sel      = PC_IRQ;
          w_ctrl.ifid_flush  = 1'b1;
          w_ctrl.idex_flush  = 1'b1;
          w_ctrl.exmem_flush = 1'b1;
          w_ctrl.irq_ack     = 1'b1;
          w_state_nxt        = ST_RUN;
        end
        ST_IRQ_DRAIN: begin
          w_drain_adv = 1'b1;
          if (EX_br_taken) begin
            w_ctrl.pc_sel     = PC_BR;
            w_ctrl.ifid_flush = 1'b1;
            w_ctrl.idex_flush = 1'b1;
          end else if (w_load_use) begin
            // Held instruction is not a bubble, so this cycle does not count as drain.
            w_ctrl.pc_en      = 1'b0;
            w_ctrl.ifid_en    = 1'b0;
            w_ctrl.idex_flush = 1'b1;
            w_drain_adv       = 1'b0;
          end else if (ID_jump) begin
            w_ctrl.pc_sel     = PC_JMP;
            w_ctrl.ifid_flush = 1'b1;
          end else begin
            w_ctrl.pc_en      = 1'b0;
            w_ctrl.ifid_flush = 1'b1;
          end
          if (w_drain_adv) begin
            if (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
              w_drain_nxt = '0;
              w_state_nxt = ST_IRQ_ENTER;
            end else begin
              w_drain_nxt = r_drain_cnt + DRAIN_W'(1);
            end
          end
        end
        default: begin
          if (EX_br_taken) begin
            w_ctrl.pc_sel     = PC_BR;
            w_ctrl.ifid_flush = 1'b1;
            w_ctrl.idex_flush = 1'b1;
          end else if (w_load_use) begin
            w_ctrl.pc_en      = 1'b0;
            w_ctrl.ifid_en    = 1'b0;
            w_ctrl.idex_flush = 1'b1;
          end else if (ID_jump) begin
            w_ctrl.pc_sel     = PC_JMP;
            w_ctrl.ifid_flush = 1'b1;
          end
          if (irq) begin
            w_state_nxt = ST_IRQ_DRAIN;
            w_drain_nxt = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_ret_state <= ST_RUN;
      r_wait_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (!w_ctrl.pc_en && (r_stall_cnt != {PERF_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  assign pc_en       = w_ctrl.pc_en;
  assign pc_sel      = w_ctrl.pc_sel;
  assign ifid_en     = w_ctrl.ifid_en;
  assign idex_en     = w_ctrl.idex_en;
  assign exmem_en    = w_ctrl.exmem_en;
  assign memwb_en    = w_ctrl.memwb_en;
  assign ifid_flush  = w_ctrl.ifid_flush;
  assign idex_flush  = w_ctrl.idex_flush;
  assign exmem_flush = w_ctrl.exmem_flush;
  assign irq_ack     = w_ctrl.irq_ack;
  assign mem_timeout = w_ctrl.mem_timeout;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expectations queued with each stimulus
// cycle and compared against the DUT on the following falling edge.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IFID_rs, IFID_rt, IDEX_AddrC, IDEX_rs, IDEX_rt, EXMEM_AddrC, MEMWB_AddrC;
  logic        ID_uses_rt, ID_jump, IDEX_MemRead, EX_br_taken;
  logic        EXMEM_RegWr, MEMWB_RegWr, dmem_req, dmem_ready, irq;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, irq_ack, mem_timeout;
  logic [1:0]  pc_sel, fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  typedef struct {
    string      tag;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic [3:0] en;
    logic [2:0] fl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       ack;
    logic       tmo;
    logic [15:0] sc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned exp_stalls = 0;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .WAIT_MAX(15), .PERF_W(16)) dut (
    .clk(clk), .reset(reset),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .ID_uses_rt(ID_uses_rt), .ID_jump(ID_jump),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_AddrC(IDEX_AddrC), .IDEX_rs(IDEX_rs), .IDEX_rt(IDEX_rt),
    .EX_br_taken(EX_br_taken), .EXMEM_RegWr(EXMEM_RegWr), .EXMEM_AddrC(EXMEM_AddrC),
    .MEMWB_RegWr(MEMWB_RegWr), .MEMWB_AddrC(MEMWB_AddrC),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .irq(irq),
    .pc_en(pc_en), .pc_sel(pc_sel),
    .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .irq_ack(irq_ack), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    IFID_rs = '0; IFID_rt = '0; ID_uses_rt = 0; ID_jump = 0;
    IDEX_MemRead = 0; IDEX_AddrC = '0; IDEX_rs = '0; IDEX_rt = '0;
    EX_br_taken = 0; EXMEM_RegWr = 0; EXMEM_AddrC = '0;
    MEMWB_RegWr = 0; MEMWB_AddrC = '0; dmem_req = 0; dmem_ready = 0; irq = 0;
  endtask

  task automatic pop_cmp();
    exp_t e;
    e = sb_q.pop_front();
    check_eq({e.tag, ".pc_en"},  32'(pc_en),  32'(e.pc_en));
    check_eq({e.tag, ".pc_sel"}, 32'(pc_sel), 32'(e.pc_sel));
    check_eq({e.tag, ".en"},     32'({ifid_en, idex_en, exmem_en, memwb_en}), 32'(e.en));
    check_eq({e.tag, ".flush"},  32'({ifid_flush, idex_flush, exmem_flush}), 32'(e.fl));
    check_eq({e.tag, ".fwd_a"},  32'(fwd_a), 32'(e.fa));
    check_eq({e.tag, ".fwd_b"},  32'(fwd_b), 32'(e.fb));
    check_eq({e.tag, ".irq_ack"}, 32'(irq_ack), 32'(e.ack));
    check_eq({e.tag, ".mem_timeout"}, 32'(mem_timeout), 32'(e.tmo));
    check_eq({e.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
  endtask

  // Queue the expectation for the cycle just driven, then compare mid-cycle.
  task automatic step(input string tag, input logic pe, input logic [1:0] ps,
                      input logic [3:0] en, input logic [2:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic ack, input logic tmo);
    exp_t e;
    e.tag = tag; e.pc_en = pe; e.pc_sel = ps; e.en = en; e.fl = fl;
    e.fa = fa; e.fb = fb; e.ack = ack; e.tmo = tmo; e.sc = 16'(exp_stalls);
    sb_q.push_back(e);
    if (!pe) exp_stalls++;
    @(negedge clk);
    pop_cmp();
    @(posedge clk);
    #1;
  endtask

  task automatic step_def(input string tag);
    step(tag, 1'b1, 2'b00, 4'b1111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic step_frz(input string tag);
    step(tag, 1'b0, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic step_drain(input string tag);
    step(tag, 1'b0, 2'b00, 4'b1111, 3'b100, 2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic step_enter(input string tag);
    step(tag, 1'b1, 2'b11, 4'b1111, 3'b111, 2'b00, 2'b00, 1'b1, 1'b0);
  endtask

  initial begin : stim
    reset = 1'b0;
    idle();
    step_def("reset");
    reset = 1'b1;
    step_def("idle");

    // load-use on rs, then bubble, then forward from MEM/WB
    IDEX_MemRead = 1; IDEX_AddrC = 5'd5; IFID_rs = 5'd5;
    step("lu_rs", 1'b0, 2'b00, 4'b0111, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0);
    IDEX_MemRead = 0; IDEX_AddrC = '0; EXMEM_RegWr = 1; EXMEM_AddrC = 5'd5;
    step_def("lu_bubble");
    IFID_rs = '0; EXMEM_RegWr = 0; EXMEM_AddrC = '0;
    MEMWB_RegWr = 1; MEMWB_AddrC = 5'd5; IDEX_rs = 5'd5;
    step("lu_fwd", 1'b1, 2'b00, 4'b1111, 3'b000, 2'b01, 2'b00, 1'b0, 1'b0);

    // load-use on rt only when rt is actually read; r0 never hazards
    idle(); IDEX_MemRead = 1; IDEX_AddrC = 5'd6; IFID_rt = 5'd6; ID_uses_rt = 1;
    step("lu_rt", 1'b0, 2'b00, 4'b0111, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0);
    ID_uses_rt = 0;
    step_def("lu_rt_unused");
    idle(); IDEX_MemRead = 1;
    step_def("lu_r0");

    // forwarding priority
    idle(); EXMEM_RegWr = 1; EXMEM_AddrC = 5'd7; MEMWB_RegWr = 1; MEMWB_AddrC = 5'd7;
    IDEX_rs = 5'd7; IDEX_rt = 5'd7;
    step("fwd_mem", 1'b1, 2'b00, 4'b1111, 3'b000, 2'b10, 2'b10, 1'b0, 1'b0);
    EXMEM_RegWr = 0;
    step("fwd_wb", 1'b1, 2'b00, 4'b1111, 3'b000, 2'b01, 2'b01, 1'b0, 1'b0);
    EXMEM_RegWr = 1; EXMEM_AddrC = '0; MEMWB_AddrC = '0; IDEX_rs = '0; IDEX_rt = '0;
    step_def("fwd_r0");
    EXMEM_AddrC = 5'd3; MEMWB_AddrC = 5'd4; IDEX_rs = 5'd4; IDEX_rt = 5'd3;
    step("fwd_mix", 1'b1, 2'b00, 4'b1111, 3'b000, 2'b01, 2'b10, 1'b0, 1'b0);

    // branch and jump priorities
    idle(); IDEX_MemRead = 1; IDEX_AddrC = 5'd5; IFID_rs = 5'd5; EX_br_taken = 1;
    step("br_lu", 1'b1, 2'b01, 4'b1111, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);
    idle(); ID_jump = 1;
    step("jmp", 1'b1, 2'b10, 4'b1111, 3'b100, 2'b00, 2'b00, 1'b0, 1'b0);
    IDEX_MemRead = 1; IDEX_AddrC = 5'd5; IFID_rs = 5'd5;
    step("jmp_lu", 1'b0, 2'b00, 4'b0111, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0);
    idle(); ID_jump = 1; EX_br_taken = 1;
    step("jmp_br", 1'b1, 2'b01, 4'b1111, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);

    // asynchronous reset in the middle of a memory wait
    idle(); dmem_req = 1;
    step_frz("w_pre0");
    step_frz("w_pre1");
    #2;
    reset = 1'b0; dmem_req = 0;
    #1;
    exp_stalls = 0;
    check_eq("arst.stall_cnt", 32'(stall_cnt), 32'd0);
    check_eq("arst.en", 32'({ifid_en, idex_en, exmem_en, memwb_en}), 32'hf);
    check_eq("arst.pc_en", 32'(pc_en), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step_def("arst_run");

    // four-cycle data-memory wait
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) step_frz("wait4");
    dmem_ready = 1;
    step_def("wait4_done");
    check_eq("wait4.stall_cnt", 32'(stall_cnt), 32'd4);

    // memory never ready: abort on the 15th wait cycle
    idle(); dmem_req = 1;
    for (int i = 0; i < 14; i++) step_frz("tmo_wait");
    step("tmo", 1'b1, 2'b00, 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 1'b1);
    dmem_req = 0;
    step_def("tmo_after");

    // interrupt drain and entry; irq held during drain is ignored
    irq = 1;
    step_def("irq_run");
    for (int i = 0; i < 3; i++) step_drain("irq_drain");
    irq = 0;
    step_enter("irq_enter");
    step_def("irq_done");

    // memory freeze in the middle of a drain resumes the drain
    irq = 1;
    step_def("irq2_run");
    irq = 0;
    step_drain("irq2_drain1");
    dmem_req = 1; dmem_ready = 0;
    step_frz("irq2_frz0");
    step_frz("irq2_frz1");
    dmem_ready = 1;
    step_drain("irq2_drain2");
    dmem_req = 0; dmem_ready = 0;
    step_drain("irq2_drain3");
    step_enter("irq2_enter");
    step_def("irq2_done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
